wb_dmem_responder: RTL and testbench

Memory-side responder for the write-back data cache's line-transfer interface. It accepts one cache-line read (allocate) or write (write-back) request at a time and splits it into sequential word beats on a single-word backing-memory port. It returns one `mem2dcache_ack_o` pulse when the line transfer completes. The block sits between the data cache and the data memory/bus, and honours the cache's kill signal.

---
 rtl/wb_dmem_responder.sv | 204 ++++++++++++++++++++
 tb/tb_wb_dmem_responder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : wb_dmem_responder
//  Purpose  : Memory-side responder for the write-back data cache line-transfer
//             interface. A line read (allocate) or line write (write-back) is
//             accepted in IDLE. It is then split into BEATS sequential word
//             beats on a single-word backing-memory port. The cache receives
//             a single completion pulse when the whole line has transferred.
//             The cache kill input aborts a transfer. The beat already on the
//             bus is always allowed to finish, because the memory side cannot
//             be abandoned mid-handshake.
//
//  Ports    : clk_i / rst_i           clock, asynchronous active-high reset
//             dcache2mem_req_i        line request (held until ack or kill)
//             dcache2mem_wr_i         1 = write-back, 0 = line read
//             dcache2mem_kill_i       abort current request
//             dcache2mem_addr_i       line byte address (low LOFF bits ignored)
//             dcache2mem_data_i       write-back line data
//             mem2dcache_ack_o        one-cycle completion pulse
//             mem2dcache_data_o       read line data
//             bmem_req_o / bmem_we_o  beat request / beat write enable
//             bmem_addr_o             beat byte address
//             bmem_wdata_o            beat write data
//             bmem_rdata_i            beat read data (valid with bmem_ack_i)
//             bmem_ack_i              beat complete (may coincide with req)
//
//  Options  : DMEM_RESP_BYPASS_EN - when defined, the RESP state is removed.
//             The cache ack is raised combinationally with the last beat's
//             memory ack. The final read word is forwarded straight into the
//             top slot of mem2dcache_data_o in that cycle.
//
//  Revision : 1.0 - initial release
// ============================================================================
module wb_dmem_responder #(
   parameter int LINE_WIDTH = 128,
   parameter int WORD_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  dcache2mem_req_i,
   input  logic                  dcache2mem_wr_i,
   input  logic                  dcache2mem_kill_i,
   input  logic [ADDR_WIDTH-1:0] dcache2mem_addr_i,
   input  logic [LINE_WIDTH-1:0] dcache2mem_data_i,
   output logic                  mem2dcache_ack_o,
   output logic [LINE_WIDTH-1:0] mem2dcache_data_o,
   output logic                  bmem_req_o,
   output logic                  bmem_we_o,
   output logic [ADDR_WIDTH-1:0] bmem_addr_o,
   output logic [WORD_WIDTH-1:0] bmem_wdata_o,
   input  logic [WORD_WIDTH-1:0] bmem_rdata_i,
   input  logic                  bmem_ack_i
);

   localparam int BEATS = LINE_WIDTH / WORD_WIDTH;
   localparam int WOFF  = $clog2(WORD_WIDTH / 8);
   localparam int LOFF  = $clog2(LINE_WIDTH / 8);
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [BW-1:0]         LAST_BEAT = BW'(BEATS - 1);
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << LOFF;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BEAT  = 2'd1;
`ifndef DMEM_RESP_BYPASS_EN
   localparam logic [1:0] RESP  = 2'd2;
`endif
   localparam logic [1:0] DRAIN = 2'd3;

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic [BW-1:0]         beat;
   logic [ADDR_WIDTH-1:0] base;
   logic                  wr;
   logic [LINE_WIDTH-1:0] wline;
   logic [LINE_WIDTH-1:0] rline;

   logic                  accept;
   logic                  last_beat;
   logic                  beat_done;
   logic [31:0]           beat_lsb;

   assign accept    = dcache2mem_req_i & ~dcache2mem_kill_i;
   assign last_beat = (beat == LAST_BEAT);
   assign beat_done = (state == BEAT) & bmem_ack_i;
   assign beat_lsb  = 32'(beat) * 32'(WORD_WIDTH);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = BEAT;
            end
         end
         BEAT: begin
            if (bmem_ack_i) begin
               // Kill beats completion: the finishing beat is the last one
               // issued, and no cache ack follows.
               if (dcache2mem_kill_i) begin
                  state_nxt = IDLE;
               end else if (last_beat) begin
`ifdef DMEM_RESP_BYPASS_EN
                  state_nxt = IDLE;
`else
                  state_nxt = RESP;
`endif
               end
            end else if (dcache2mem_kill_i) begin
               // The in-flight beat must still complete on the memory side.
               state_nxt = DRAIN;
            end
         end
`ifndef DMEM_RESP_BYPASS_EN
         RESP: begin
            state_nxt = IDLE;
         end
`endif
         DRAIN: begin
            if (bmem_ack_i) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------
   always_comb begin
      bmem_req_o        = 1'b0;
      bmem_we_o         = 1'b0;
      bmem_addr_o       = '0;
      bmem_wdata_o      = '0;
      mem2dcache_ack_o  = 1'b0;
      mem2dcache_data_o = rline;

      // Beat counter is frozen in DRAIN, so the held beat keeps a stable
      // address and write data until memory acknowledges it.
      if ((state == BEAT) || (state == DRAIN)) begin
         bmem_req_o   = 1'b1;
         bmem_we_o    = wr;
         bmem_addr_o  = base + (ADDR_WIDTH'(beat) << WOFF);
         bmem_wdata_o = wline[beat_lsb +: WORD_WIDTH];
      end

`ifdef DMEM_RESP_BYPASS_EN
      if (beat_done && last_beat && !dcache2mem_kill_i) begin
         mem2dcache_ack_o = 1'b1;
         if (!wr) begin
            mem2dcache_data_o[(BEATS-1)*WORD_WIDTH +: WORD_WIDTH] = bmem_rdata_i;
         end
      end
`else
      mem2dcache_ack_o = (state == RESP) & ~dcache2mem_kill_i;
`endif
   end

   // ------------------------------------------------------------------
   // Request latch, beat counter and read-line assembly
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         beat  <= '0;
         base  <= '0;
         wr    <= 1'b0;
         wline <= '0;
         rline <= '0;
      end else begin
         if ((state == IDLE) && accept) begin
            base  <= dcache2mem_addr_i & LINE_MASK;
            wr    <= dcache2mem_wr_i;
            wline <= dcache2mem_data_i;
            beat  <= '0;
         end else if (beat_done) begin
            // A beat completing under kill has its read data dropped.
            if (!wr && !dcache2mem_kill_i) begin
               rline[beat_lsb +: WORD_WIDTH] <= bmem_rdata_i;
            end
            beat <= beat + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_dmem_responder
//  Purpose  : Directed self-checking bench for wb_dmem_responder at default
//             parameters. The backing memory acks whenever ack_en is set.
//             Read data is rdata_base OR'd with the beat index taken from
//             address bits [3:2].
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_dmem_responder;

`ifdef DMEM_RESP_BYPASS_EN
   localparam int RESP_LAT = 4;
`else
   localparam int RESP_LAT = 5;
`endif
   localparam logic [127:0] READ_LINE_A = 128'h000000A3_000000A2_000000A1_000000A0;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         dreq = 1'b0;
   logic         dwr = 1'b0;
   logic         dkill = 1'b0;
   logic [31:0]  daddr = '0;
   logic [127:0] dline = '0;
   logic         mack;
   logic [127:0] mdata;
   logic         breq;
   logic         bwe;
   logic [31:0]  baddr;
   logic [31:0]  bwdata;
   logic [31:0]  brdata;
   logic         back;

   logic         ack_en = 1'b0;
   logic [31:0]  rdata_base = '0;

   int           n_checks = 0;
   int           n_fail = 0;

   int           ack_cyc;
   int           nbeats;
   logic [127:0] ack_data;
   logic [31:0]  beat_addr [0:7];
   logic [31:0]  beat_wdata [0:7];
   logic         beat_we [0:7];

   assign back   = breq & ack_en;
   assign brdata = rdata_base | {30'b0, baddr[3:2]};

   always #5 clk = ~clk;

   wb_dmem_responder dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .dcache2mem_req_i  (dreq),
      .dcache2mem_wr_i   (dwr),
      .dcache2mem_kill_i (dkill),
      .dcache2mem_addr_i (daddr),
      .dcache2mem_data_i (dline),
      .mem2dcache_ack_o  (mack),
      .mem2dcache_data_o (mdata),
      .bmem_req_o        (breq),
      .bmem_we_o         (bwe),
      .bmem_addr_o       (baddr),
      .bmem_wdata_o      (bwdata),
      .bmem_rdata_i      (brdata),
      .bmem_ack_i        (back)
   );

   // Issues one line request and plays memory with 'waits' stall cycles per
   // beat; records each completed beat and the cycle (relative to the accept
   // edge T) in which the cache ack is seen. ack_cyc = -1 if none in budget.
   task automatic run_line(input logic wr, input logic [31:0] addr,
                           input logic [127:0] line, input int waits);
      int wc;
      wc = 0;
      ack_cyc = -1;
      nbeats = 0;
      @(negedge clk);
      dreq = 1'b1; dwr = wr; daddr = addr; dline = line; dkill = 1'b0; ack_en = 1'b0;
      @(posedge clk);
      for (int n = 1; n <= 40 && ack_cyc < 0; n++) begin
         @(negedge clk);
         if (breq) begin
            if (wc < waits) begin
               ack_en = 1'b0;
               wc++;
            end else begin
               ack_en = 1'b1;
               wc = 0;
            end
         end else begin
            ack_en = 1'b0;
         end
         #1;
         if (back && nbeats < 8) begin
            beat_addr[nbeats]  = baddr;
            beat_wdata[nbeats] = bwdata;
            beat_we[nbeats]    = bwe;
            nbeats++;
         end
         if (mack) begin
            ack_cyc  = n;
            ack_data = mdata;
            dreq     = 1'b0;
         end
      end
      ack_en = 1'b0;
      dreq   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (breq !== 1'b0) begin n_fail++; $display("FAIL reset_breq: got %b want 0", breq); end
      n_checks++;
      if (mack !== 1'b0) begin n_fail++; $display("FAIL reset_mack: got %b want 0", mack); end
      n_checks++;
      if ({bwe, baddr, bwdata} !== 65'd0) begin
         n_fail++; $display("FAIL reset_bmem: got we=%b addr=%h wdata=%h want all 0", bwe, baddr, bwdata);
      end
      n_checks++;
      if (mdata !== 128'd0) begin n_fail++; $display("FAIL reset_mdata: got %h want 0", mdata); end
      rst = 1'b0;
   endtask

   task automatic test_read_zero_wait();
      rdata_base = 32'hA0;
      run_line(1'b0, 32'h0000_1234, 128'd0, 0);
      n_checks++;
      if (ack_cyc != RESP_LAT) begin n_fail++; $display("FAIL read_ack_cycle: got %0d want %0d", ack_cyc, RESP_LAT); end
      n_checks++;
      if (nbeats != 4) begin n_fail++; $display("FAIL read_beats: got %0d want 4", nbeats); end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if ({beat_we[k], beat_addr[k]} !== {1'b0, 32'h1230 + 32'(4 * k)}) begin
            n_fail++;
            $display("FAIL read_beat%0d: got we=%b addr=%h want we=0 addr=%h", k, beat_we[k], beat_addr[k], 32'h1230 + 32'(4 * k));
         end
      end
      n_checks++;
      if (ack_data !== READ_LINE_A) begin n_fail++; $display("FAIL read_data: got %h want %h", ack_data, READ_LINE_A); end
      @(negedge clk);
      #1;
      n_checks++;
      if ({mack, breq} !== 2'b00) begin n_fail++; $display("FAIL read_after_ack: got mack=%b breq=%b want 0 0", mack, breq); end
      n_checks++;
      if (mdata !== READ_LINE_A) begin n_fail++; $display("FAIL read_data_hold: got %h want %h", mdata, READ_LINE_A); end
   endtask

   task automatic test_write_wait();
      run_line(1'b1, 32'h0000_2000, 128'h4444_4444_3333_3333_2222_2222_1111_1111, 1);
      n_checks++;
      if (ack_cyc != RESP_LAT + 4) begin n_fail++; $display("FAIL write_ack_cycle: got %0d want %0d", ack_cyc, RESP_LAT + 4); end
      n_checks++;
      if (nbeats != 4) begin n_fail++; $display("FAIL write_beats: got %0d want 4", nbeats); end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if ({beat_we[k], beat_addr[k], beat_wdata[k]} !==
             {1'b1, 32'h2000 + 32'(4 * k), 32'(32'h1111_1111 * (k + 1))}) begin
            n_fail++;
            $display("FAIL write_beat%0d: got we=%b addr=%h wdata=%h want we=1 addr=%h wdata=%h", k,
                     beat_we[k], beat_addr[k], beat_wdata[k], 32'h2000 + 32'(4 * k), 32'(32'h1111_1111 * (k + 1)));
         end
      end
      n_checks++;
      if (ack_data !== READ_LINE_A) begin n_fail++; $display("FAIL write_data_unchanged: got %h want %h", ack_data, READ_LINE_A); end
   endtask

   task automatic test_kill_stall();
      rdata_base = 32'h5550;
      @(negedge clk);
      dreq = 1'b1; dwr = 1'b0; daddr = 32'h0000_3000; dkill = 1'b0; ack_en = 1'b0;
      @(posedge clk);
      @(negedge clk); ack_en = 1'b1; #1;                      // T+1: beat 0
      n_checks++;
      if ({breq, baddr} !== {1'b1, 32'h3000}) begin n_fail++; $display("FAIL kill_beat0: got req=%b addr=%h want 1 3000", breq, baddr); end
      @(negedge clk); ack_en = 1'b0; dkill = 1'b1; #1;        // T+2: beat 1 stalled, kill
      n_checks++;
      if ({breq, baddr} !== {1'b1, 32'h3004}) begin n_fail++; $display("FAIL kill_beat1: got req=%b addr=%h want 1 3004", breq, baddr); end
      for (int c = 0; c < 2; c++) begin                        // T+3, T+4: still stalled
         @(negedge clk); dkill = 1'b0; dreq = 1'b0; #1;
         n_checks++;
         if ({breq, mack, baddr} !== {2'b10, 32'h3004}) begin
            n_fail++; $display("FAIL kill_drain_hold%0d: got req=%b ack=%b addr=%h want 1 0 3004", c, breq, mack, baddr);
         end
      end
      @(negedge clk); ack_en = 1'b1; #1;                      // T+5: beat 1 completes
      n_checks++;
      if ({breq, mack, baddr} !== {2'b10, 32'h3004}) begin
         n_fail++; $display("FAIL kill_drain_ack: got req=%b ack=%b addr=%h want 1 0 3004", breq, mack, baddr);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); ack_en = 1'b0; #1;
         n_checks++;
         if ({breq, mack} !== 2'b00) begin n_fail++; $display("FAIL kill_idle%0d: got req=%b ack=%b want 0 0", c, breq, mack); end
      end
      n_checks++;
      if (mdata !== 128'h000000A3_000000A2_000000A1_00005550) begin
         n_fail++; $display("FAIL kill_rline: got %h want 000000a3000000a2000000a100005550", mdata);
      end
   endtask

   task automatic test_kill_last_back_to_back();
      int got;
      logic [127:0] got_data;
      got = -1;
      got_data = '0;
      rdata_base = 32'h6660;
      @(negedge clk);
      dreq = 1'b1; dwr = 1'b0; daddr = 32'h0000_4000; dkill = 1'b0; ack_en = 1'b1;
      @(posedge clk);
      repeat (3) @(negedge clk);                               // T+1..T+3: beats 0..2
      @(negedge clk); dkill = 1'b1; #1;                       // T+4: last beat with kill
      n_checks++;
      if ({breq, mack} !== 2'b10) begin n_fail++; $display("FAIL killlast_beat3: got req=%b ack=%b want 1 0", breq, mack); end
      @(negedge clk); dkill = 1'b0; daddr = 32'h0000_5000; rdata_base = 32'h7770; #1;   // T+5
      n_checks++;
      if ({breq, mack} !== 2'b00) begin n_fail++; $display("FAIL killlast_idle: got req=%b ack=%b want 0 0", breq, mack); end
      n_checks++;
      if (mdata !== 128'h000000A3_00006662_00006661_00006660) begin
         n_fail++; $display("FAIL killlast_rline: got %h want 000000a3000066620000666100006660", mdata);
      end
      for (int n = 6; n <= 30 && got < 0; n++) begin
         @(negedge clk); #1;
         if (n == 6) begin
            n_checks++;
            if ({breq, baddr} !== {1'b1, 32'h5000}) begin
               n_fail++; $display("FAIL killlast_next_req: got req=%b addr=%h want 1 5000", breq, baddr);
            end
         end
         if (mack) begin
            got = n;
            got_data = mdata;
            dreq = 1'b0;
         end
      end
      ack_en = 1'b0;
      dreq = 1'b0;
      n_checks++;
      if (got != 5 + RESP_LAT) begin n_fail++; $display("FAIL killlast_next_ack: got %0d want %0d", got, 5 + RESP_LAT); end
      n_checks++;
      if (got_data !== 128'h00007773_00007772_00007771_00007770) begin
         n_fail++; $display("FAIL killlast_next_data: got %h want 00007773000077720000777100007770", got_data);
      end
   endtask

   task automatic test_reset_mid_beat();
      rdata_base = 32'h9990;
      @(negedge clk);
      dreq = 1'b1; dwr = 1'b0; daddr = 32'h0000_8000; dkill = 1'b0; ack_en = 1'b1;
      @(posedge clk);
      repeat (2) @(negedge clk);                               // beats 0, 1
      @(negedge clk); ack_en = 1'b0; #1;                      // beat 2 stalled
      n_checks++;
      if ({breq, baddr} !== {1'b1, 32'h8008}) begin n_fail++; $display("FAIL rstmid_beat2: got req=%b addr=%h want 1 8008", breq, baddr); end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({breq, bwe, mack} !== 3'b000) begin n_fail++; $display("FAIL rstmid_ctrl: got req=%b we=%b ack=%b want 0 0 0", breq, bwe, mack); end
      n_checks++;
      if ({baddr, bwdata} !== 64'd0) begin n_fail++; $display("FAIL rstmid_bus: got addr=%h wdata=%h want 0 0", baddr, bwdata); end
      n_checks++;
      if (mdata !== 128'd0) begin n_fail++; $display("FAIL rstmid_mdata: got %h want 0", mdata); end
      dreq = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      rdata_base = 32'hA0;
      run_line(1'b0, 32'h0000_1234, 128'd0, 0);
      n_checks++;
      if (ack_cyc != RESP_LAT) begin n_fail++; $display("FAIL rstmid_after_ack: got %0d want %0d", ack_cyc, RESP_LAT); end
      n_checks++;
      if (ack_data !== READ_LINE_A) begin n_fail++; $display("FAIL rstmid_after_data: got %h want %h", ack_data, READ_LINE_A); end
   endtask

   initial begin
      test_reset();
      test_read_zero_wait();
      test_write_wait();
      test_kill_stall();
      test_kill_last_back_to_back();
      test_reset_mid_beat();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
